// File: rtl/uart_stream.sv
`default_nettype none
// ============================================================================
// Module   : uart_stream
// Purpose  : Parametrised streaming UART with configurable frame format,
//            TX/RX FIFOs, 16x oversampled majority-vote receiver, per-byte
//            error tagging and a sticky RX overrun flag.
// Ports    : clk, reset (async, active-low)
//            to_uart_*   : TX valid/ready stream into the TX FIFO
//            from_uart_* : RX valid/ready stream out of the RX FIFO (FWFT)
//            rx_overrun / clear_overrun : sticky drop indicator and its clear
//            UART_RXD / UART_TXD        : serial line
// Revision : 1.0 - initial release
// ============================================================================
module uart_stream #(
    parameter int BAUD_DIV  = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] to_uart_data,
    input  logic       to_uart_valid,
    input  logic       to_uart_error,
    output logic       to_uart_ready,
    output logic [7:0] from_uart_data,
    output logic       from_uart_valid,
    output logic       from_uart_error,
    input  logic       from_uart_ready,
    output logic       rx_overrun,
    input  logic       clear_overrun,
    input  logic       UART_RXD,
    output logic       UART_TXD
);
    localparam int c_OS_DIV = BAUD_DIV / 16;
    localparam int c_DIV_W  = $clog2(BAUD_DIV);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);
    localparam int c_TXA_W  = $clog2(TX_DEPTH);
    localparam int c_RXA_W  = $clog2(RX_DEPTH);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(BAUD_DIV - 1);
    // Tick n of a bit lands on divider count n*OS_DIV-1.
    localparam logic [c_DIV_W-1:0] c_TICK7     = c_DIV_W'(7 * c_OS_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_TICK8     = c_DIV_W'(8 * c_OS_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_TICK9     = c_DIV_W'(9 * c_OS_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);
    localparam logic [7:0]         c_DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);

    localparam logic [2:0] c_TX_IDLE   = 3'd0;
    localparam logic [2:0] c_TX_START  = 3'd1;
    localparam logic [2:0] c_TX_DATA   = 3'd2;
    localparam logic [2:0] c_TX_PARITY = 3'd3;
    localparam logic [2:0] c_TX_STOP   = 3'd4;

    localparam logic [2:0] c_RX_IDLE   = 3'd0;
    localparam logic [2:0] c_RX_START  = 3'd1;
    localparam logic [2:0] c_RX_DATA   = 3'd2;
    localparam logic [2:0] c_RX_PARITY = 3'd3;
    localparam logic [2:0] c_RX_STOP   = 3'd4;
    localparam logic [2:0] c_RX_BREAK  = 3'd5;

    // ------------------------------------------------------------------ TX FIFO
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [c_TXA_W:0] r_tx_wr_ptr, r_tx_rd_ptr;
    logic             w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic [7:0]       w_tx_head;
    logic             w_tx_par;

    assign w_tx_empty    = (r_tx_wr_ptr == r_tx_rd_ptr);
    assign w_tx_full     = (r_tx_wr_ptr[c_TXA_W] != r_tx_rd_ptr[c_TXA_W]) &&
                           (r_tx_wr_ptr[c_TXA_W-1:0] == r_tx_rd_ptr[c_TXA_W-1:0]);
    assign to_uart_ready = ~w_tx_full;
    // Poisoned beats complete the handshake but never occupy an entry.
    assign w_tx_push     = to_uart_valid & ~w_tx_full & ~to_uart_error;
    assign w_tx_head     = r_tx_mem[r_tx_rd_ptr[c_TXA_W-1:0]] & c_DATA_MASK;
    assign w_tx_par      = (PARITY == 1) ? ~(^w_tx_head) : (^w_tx_head);

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr_ptr[c_TXA_W-1:0]] <= to_uart_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------ TX FSM
    logic [2:0]         r_tx_state;
    logic [c_DIV_W-1:0] r_tx_div;
    logic [c_BIT_W-1:0] r_tx_bit;
    logic [7:0]         r_tx_shift;
    logic               r_tx_par, r_txd, w_txd_next, w_tx_bit_end, w_tx_frame_end;

    assign w_tx_bit_end   = (r_tx_div == c_DIV_LAST);
    assign w_tx_frame_end = (r_tx_state == c_TX_STOP) && w_tx_bit_end &&
                            (r_tx_bit == c_STOP_LAST);
    // Popping on the last stop clock starts the next frame with no idle gap.
    assign w_tx_pop       = ~w_tx_empty & ((r_tx_state == c_TX_IDLE) | w_tx_frame_end);
    assign UART_TXD       = r_txd;

    always_comb begin
        w_txd_next = 1'b1;
        case (r_tx_state)
            c_TX_START:  w_txd_next = 1'b0;
            c_TX_DATA:   w_txd_next = r_tx_shift[0];
            c_TX_PARITY: w_txd_next = r_tx_par;
            default:     w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= c_TX_IDLE;
            r_tx_div   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_txd <= w_txd_next;
            if (w_tx_pop) begin
                r_tx_state <= c_TX_START;
                r_tx_div   <= '0;
                r_tx_bit   <= '0;
                r_tx_shift <= w_tx_head;
                r_tx_par   <= w_tx_par;
            end else if (r_tx_state != c_TX_IDLE) begin
                if (w_tx_bit_end) begin
                    r_tx_div <= '0;
                    case (r_tx_state)
                        c_TX_START: r_tx_state <= c_TX_DATA;
                        c_TX_DATA: begin
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            if (r_tx_bit == c_DATA_LAST) begin
                                r_tx_bit   <= '0;
                                r_tx_state <= (PARITY != 0) ? c_TX_PARITY : c_TX_STOP;
                            end else begin
                                r_tx_bit <= r_tx_bit + 1'b1;
                            end
                        end
                        c_TX_PARITY: r_tx_state <= c_TX_STOP;
                        default: begin
                            if (r_tx_bit == c_STOP_LAST) r_tx_state <= c_TX_IDLE;
                            else                         r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    endcase
                end else begin
                    r_tx_div <= r_tx_div + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------- RX sampling
    logic r_rxd_meta, r_rxd_sync, r_rxd_last;
    logic r_s7, r_s8, w_rx_fall, w_rx_maj;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_last <= 1'b1;
        end else begin
            r_rxd_meta <= UART_RXD;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_last <= r_rxd_sync;
        end
    end

    assign w_rx_fall = r_rxd_last & ~r_rxd_sync;
    // Evaluated at tick 9: the live line value is the third vote.
    assign w_rx_maj  = (r_s7 & r_s8) | (r_s7 & r_rxd_sync) | (r_s8 & r_rxd_sync);

    // ------------------------------------------------------------------ RX FSM
    logic [2:0]         r_rx_state;
    logic [c_DIV_W-1:0] r_rx_div;
    logic [c_BIT_W-1:0] r_rx_bit;
    logic [7:0]         r_rx_shift, w_rx_shift_in, r_rx_wr_data;
    logic               r_rx_perr, r_rx_wr, r_rx_wr_err;

    // New bits enter at the top of the DATA_BITS-wide field; upper bits stay 0.
    always_comb begin
        w_rx_shift_in                = {1'b0, r_rx_shift[7:1]};
        w_rx_shift_in[DATA_BITS-1]   = w_rx_maj;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state   <= c_RX_IDLE;
            r_rx_div     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_perr    <= 1'b0;
            r_rx_wr      <= 1'b0;
            r_rx_wr_data <= '0;
            r_rx_wr_err  <= 1'b0;
            r_s7         <= 1'b1;
            r_s8         <= 1'b1;
        end else begin
            r_rx_wr <= 1'b0;
            if (r_rx_div == c_TICK7) r_s7 <= r_rxd_sync;
            if (r_rx_div == c_TICK8) r_s8 <= r_rxd_sync;
            case (r_rx_state)
                c_RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= c_RX_START;
                        r_rx_div   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_shift <= '0;
                        r_rx_perr  <= 1'b0;
                    end
                end
                c_RX_START: begin
                    if (r_rx_div == c_TICK8 && r_rxd_sync) begin
                        r_rx_state <= c_RX_IDLE;
                        r_rx_div   <= '0;
                    end else if (r_rx_div == c_DIV_LAST) begin
                        r_rx_state <= c_RX_DATA;
                        r_rx_div   <= '0;
                    end else begin
                        r_rx_div <= r_rx_div + 1'b1;
                    end
                end
                c_RX_DATA: begin
                    if (r_rx_div == c_TICK9) r_rx_shift <= w_rx_shift_in;
                    if (r_rx_div == c_DIV_LAST) begin
                        r_rx_div <= '0;
                        if (r_rx_bit == c_DATA_LAST) begin
                            r_rx_bit   <= '0;
                            r_rx_state <= (PARITY != 0) ? c_RX_PARITY : c_RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_div <= r_rx_div + 1'b1;
                    end
                end
                c_RX_PARITY: begin
                    if (r_rx_div == c_TICK9)
                        r_rx_perr <= (PARITY == 1) ? ~(^r_rx_shift ^ w_rx_maj)
                                                   : (^r_rx_shift ^ w_rx_maj);
                    if (r_rx_div == c_DIV_LAST) begin
                        r_rx_div   <= '0;
                        r_rx_state <= c_RX_STOP;
                    end else begin
                        r_rx_div <= r_rx_div + 1'b1;
                    end
                end
                c_RX_STOP: begin
                    // Only the first stop bit is checked; the frame is closed at
                    // its mid-point so a following start edge is never missed.
                    if (r_rx_div == c_TICK9) begin
                        r_rx_wr      <= 1'b1;
                        r_rx_wr_data <= r_rx_shift;
                        r_rx_wr_err  <= ~w_rx_maj | r_rx_perr;
                        r_rx_div     <= '0;
                        r_rx_state   <= (~w_rx_maj & ~r_rxd_sync) ? c_RX_BREAK : c_RX_IDLE;
                    end else begin
                        r_rx_div <= r_rx_div + 1'b1;
                    end
                end
                default: begin
                    if (r_rxd_sync) r_rx_state <= c_RX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------ RX FIFO
    logic [8:0]       r_rx_mem [RX_DEPTH];
    logic [c_RXA_W:0] r_rx_wr_ptr, r_rx_rd_ptr;
    logic             w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_ovr, r_overrun;
    logic [8:0]       w_rx_head;

    assign w_rx_empty      = (r_rx_wr_ptr == r_rx_rd_ptr);
    assign w_rx_full       = (r_rx_wr_ptr[c_RXA_W] != r_rx_rd_ptr[c_RXA_W]) &&
                             (r_rx_wr_ptr[c_RXA_W-1:0] == r_rx_rd_ptr[c_RXA_W-1:0]);
    assign from_uart_valid = ~w_rx_empty;
    assign w_rx_pop        = from_uart_valid & from_uart_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the write.
    assign w_rx_push       = r_rx_wr & (~w_rx_full | w_rx_pop);
    assign w_rx_ovr        = r_rx_wr & w_rx_full & ~w_rx_pop;
    assign w_rx_head       = r_rx_mem[r_rx_rd_ptr[c_RXA_W-1:0]];
    assign from_uart_data  = from_uart_valid ? w_rx_head[7:0] : 8'h00;
    assign from_uart_error = from_uart_valid & w_rx_head[8];
    assign rx_overrun      = r_overrun;

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wr_ptr[c_RXA_W-1:0]] <= {r_rx_wr_err, r_rx_wr_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
            // A fresh overrun wins over a coincident clear.
            if (w_rx_ovr)          r_overrun <= 1'b1;
            else if (clear_overrun) r_overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_stream
// Purpose  : Directed self-checking bench for uart_stream. Three instances:
//            u_a 8N1 (small FIFOs), u_b 7E2 in loopback, u_c 8O1 receive.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_stream;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u_a : 8N1, TX/RX depth 4
    logic [7:0] a_tx_data = '0;
    logic       a_tx_valid = 1'b0, a_tx_err = 1'b0, a_tx_ready;
    logic [7:0] a_rx_data;
    logic       a_rx_valid, a_rx_err, a_rx_ready = 1'b0, a_ovr, a_clr = 1'b0;
    logic       rxd_a = 1'b1, txd_a;

    // u_b : 7E2 loopback
    logic [7:0] b_tx_data = '0;
    logic       b_tx_valid = 1'b0, b_tx_ready;
    logic [7:0] b_rx_data;
    logic       b_rx_valid, b_rx_err, b_rx_ready = 1'b0, b_ovr;
    wire        line_b;

    // u_c : 8O1 receive only
    logic [7:0] c_rx_data;
    logic       c_tx_ready, c_rx_valid, c_rx_err, c_rx_ready = 1'b0, c_ovr;
    logic       rxd_c = 1'b1, txd_c;

    uart_stream #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .TX_DEPTH(4), .RX_DEPTH(4)) u_a (
        .clk(clk), .reset(rst_n),
        .to_uart_data(a_tx_data), .to_uart_valid(a_tx_valid), .to_uart_error(a_tx_err),
        .to_uart_ready(a_tx_ready),
        .from_uart_data(a_rx_data), .from_uart_valid(a_rx_valid), .from_uart_error(a_rx_err),
        .from_uart_ready(a_rx_ready),
        .rx_overrun(a_ovr), .clear_overrun(a_clr),
        .UART_RXD(rxd_a), .UART_TXD(txd_a));

    uart_stream #(.BAUD_DIV(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .reset(rst_n),
        .to_uart_data(b_tx_data), .to_uart_valid(b_tx_valid), .to_uart_error(1'b0),
        .to_uart_ready(b_tx_ready),
        .from_uart_data(b_rx_data), .from_uart_valid(b_rx_valid), .from_uart_error(b_rx_err),
        .from_uart_ready(b_rx_ready),
        .rx_overrun(b_ovr), .clear_overrun(1'b0),
        .UART_RXD(line_b), .UART_TXD(line_b));

    uart_stream #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
        .clk(clk), .reset(rst_n),
        .to_uart_data(8'h00), .to_uart_valid(1'b0), .to_uart_error(1'b0),
        .to_uart_ready(c_tx_ready),
        .from_uart_data(c_rx_data), .from_uart_valid(c_rx_valid), .from_uart_error(c_rx_err),
        .from_uart_ready(c_rx_ready),
        .rx_overrun(c_ovr), .clear_overrun(1'b0),
        .UART_RXD(rxd_c), .UART_TXD(txd_c));

    // Drives one frame LSB first, 16 clocks per bit; call and return on a negedge.
    task automatic send_rx(input int sel, input logic [15:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel == 0) rxd_a = frame[i];
            else          rxd_c = frame[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL rst_txd got %b exp 1", txd_a); end
        checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", a_rx_valid); end
        checks++; if (a_rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h exp 00", a_rx_data); end
        checks++; if (a_rx_err !== 1'b0) begin errors++; $display("FAIL rst_rx_err got %b exp 0", a_rx_err); end
        checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b exp 0", a_ovr); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b exp 1", a_tx_ready); end
    endtask

    task automatic test_tx_8n1;
        logic [9:0] exp_frame;
        exp_frame  = 10'h34A;   // 0, A5 LSB first, 1
        a_tx_data  = 8'hA5;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL tx_hs_clk0 got %b exp 1", txd_a); end
        @(negedge clk);
        checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL tx_hs_clk1 got %b exp 1", txd_a); end
        @(negedge clk);
        checks++; if (txd_a !== 1'b0) begin errors++; $display("FAIL tx_hs_clk2 got %b exp 0", txd_a); end
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            checks++; if (txd_a !== exp_frame[b]) begin errors++; $display("FAIL tx_bit%0d_first got %b exp %b", b, txd_a, exp_frame[b]); end
            repeat (14) @(negedge clk);
            checks++; if (txd_a !== exp_frame[b]) begin errors++; $display("FAIL tx_bit%0d_last got %b exp %b", b, txd_a, exp_frame[b]); end
            @(negedge clk);
        end
        checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL tx_idle_after got %b exp 1", txd_a); end
    endtask

    task automatic test_tx_poison;
        int lows;
        lows       = 0;
        a_tx_data  = 8'h00;
        a_tx_valid = 1'b1;
        a_tx_err   = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        a_tx_err   = 1'b0;
        repeat (40) begin
            if (txd_a !== 1'b1) lows++;
            @(negedge clk);
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL tx_poison_low_clocks got %0d exp 0", lows); end
    endtask

    task automatic test_loopback_7e2;
        logic [10:0] exp_f [3];
        logic [7:0]  exp_d [3];
        exp_f[0] = 11'h682; exp_f[1] = 11'h7FE; exp_f[2] = 11'h600;
        exp_d[0] = 8'h41;   exp_d[1] = 8'h7F;   exp_d[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            b_tx_data  = exp_d[i];
            b_tx_valid = 1'b1;
            @(negedge clk);
        end
        b_tx_valid = 1'b0;
        // First frame's start bit begins at this negedge; frames are 176 clocks.
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 11; b++) begin
                repeat (8) @(negedge clk);
                checks++; if (line_b !== exp_f[f][b]) begin errors++; $display("FAIL lb_line f%0d b%0d got %b exp %b", f, b, line_b, exp_f[f][b]); end
                repeat (8) @(negedge clk);
            end
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++; if (b_rx_valid !== 1'b1) begin errors++; $display("FAIL lb_rx_valid%0d got %b exp 1", i, b_rx_valid); end
            checks++; if (b_rx_data !== exp_d[i]) begin errors++; $display("FAIL lb_rx_data%0d got %h exp %h", i, b_rx_data, exp_d[i]); end
            checks++; if (b_rx_err !== 1'b0) begin errors++; $display("FAIL lb_rx_err%0d got %b exp 0", i, b_rx_err); end
            b_rx_ready = 1'b1;
            @(negedge clk);
            b_rx_ready = 1'b0;
        end
        checks++; if (b_rx_valid !== 1'b0) begin errors++; $display("FAIL lb_rx_drained got %b exp 0", b_rx_valid); end
    endtask

    task automatic test_rx_parity;
        logic [7:0] exp_d [3];
        logic       exp_e [3];
        send_rx(1, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);   // odd parity should be 1
        send_rx(1, {5'b0, 1'b1, 1'b1, 8'h81, 1'b0}, 11);
        send_rx(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        exp_d[0] = 8'h3C; exp_e[0] = 1'b1;
        exp_d[1] = 8'h81; exp_e[1] = 1'b0;
        exp_d[2] = 8'h07; exp_e[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (c_rx_data !== exp_d[i]) begin errors++; $display("FAIL par_data%0d got %h exp %h", i, c_rx_data, exp_d[i]); end
            checks++; if (c_rx_err !== exp_e[i]) begin errors++; $display("FAIL par_err%0d got %b exp %b", i, c_rx_err, exp_e[i]); end
            c_rx_ready = 1'b1;
            @(negedge clk);
            c_rx_ready = 1'b0;
        end
        checks++; if (c_rx_valid !== 1'b0) begin errors++; $display("FAIL par_drained got %b exp 0", c_rx_valid); end
    endtask

    task automatic test_rx_break;
        rxd_a = 1'b0;
        repeat (480) @(negedge clk);
        checks++; if (a_rx_valid !== 1'b1) begin errors++; $display("FAIL brk_valid got %b exp 1", a_rx_valid); end
        checks++; if (a_rx_data !== 8'h00) begin errors++; $display("FAIL brk_data got %h exp 00", a_rx_data); end
        checks++; if (a_rx_err !== 1'b1) begin errors++; $display("FAIL brk_err got %b exp 1", a_rx_err); end
        a_rx_ready = 1'b1;
        @(negedge clk);
        a_rx_ready = 1'b0;
        checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL brk_single_beat got %b exp 0", a_rx_valid); end
        rxd_a = 1'b1;
        repeat (32) @(negedge clk);
        send_rx(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
        checks++; if (a_rx_data !== 8'h55) begin errors++; $display("FAIL brk_next_data got %h exp 55", a_rx_data); end
        checks++; if (a_rx_err !== 1'b0) begin errors++; $display("FAIL brk_next_err got %b exp 0", a_rx_err); end
        a_rx_ready = 1'b1;
        @(negedge clk);
        a_rx_ready = 1'b0;
    endtask

    task automatic test_rx_overrun;
        logic [7:0] bytes [5];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
        for (int i = 0; i < 4; i++) send_rx(0, {6'b0, 1'b1, bytes[i], 1'b0}, 10);
        checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL ovr_not_yet got %b exp 0", a_ovr); end
        send_rx(0, {6'b0, 1'b1, bytes[4], 1'b0}, 10);
        checks++; if (a_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", a_ovr); end
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL ovr_cleared got %b exp 0", a_ovr); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_rx_data !== bytes[i]) begin errors++; $display("FAIL ovr_drain%0d got %h exp %h", i, a_rx_data, bytes[i]); end
            a_rx_ready = 1'b1;
            @(negedge clk);
            a_rx_ready = 1'b0;
        end
        checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained got %b exp 0", a_rx_valid); end
    endtask

    task automatic test_rx_glitch;
        rxd_a = 1'b0;
        @(negedge clk);
        rxd_a = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_beat got %b exp 0", a_rx_valid); end
    endtask

    task automatic test_reset_mid_tx;
        int lows;
        lows = 0;
        send_rx(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        checks++; if (a_rx_valid !== 1'b1) begin errors++; $display("FAIL mid_rx_held got %b exp 1", a_rx_valid); end
        for (int i = 0; i < 5; i++) begin
            a_tx_data  = (i == 0) ? 8'hF0 : 8'(i);
            a_tx_valid = 1'b1;
            @(negedge clk);
        end
        a_tx_valid = 1'b0;
        checks++; if (a_tx_ready !== 1'b0) begin errors++; $display("FAIL tx_full_ready got %b exp 0", a_tx_ready); end
        repeat (38) @(negedge clk);   // 40 clocks into frame 0xF0: data bit 1
        checks++; if (txd_a !== 1'b0) begin errors++; $display("FAIL tx_mid_frame got %b exp 0", txd_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL mid_rst_txd got %b exp 1", txd_a); end
        checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rx_valid got %b exp 0", a_rx_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_tx_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_tx_ready got %b exp 1", a_tx_ready); end
        checks++; if (a_rx_data !== 8'h00) begin errors++; $display("FAIL mid_rel_rx_data got %h exp 00", a_rx_data); end
        repeat (200) begin
            if (txd_a !== 1'b1) lows++;
            @(negedge clk);
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL mid_rel_txd_low_clocks got %0d exp 0", lows); end
        checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rel_rx_valid got %b exp 0", a_rx_valid); end
    endtask

    initial begin
        test_reset();
        test_tx_8n1();
        test_tx_poison();
        test_loopback_7e2();
        test_rx_parity();
        test_rx_break();
        test_rx_overrun();
        test_rx_glitch();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
